// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: conditions the raw pins, deframes 11-bit frames and
// resolves E0/F0 prefixes into a make-code strobe plus release/error pulses.
module ps2_key_receiver #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic       iPS2_CLK,
  input  logic       iPS2_DAT,
  output logic [7:0] oKEY_CODE,
  output logic       oKEY_EN,
  output logic       oKEY_EXT,
  output logic       oKEY_REL,
  output logic       oERR
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_clk_flt, r_clk_flt_d;
  logic [FW-1:0] r_flt_cnt;
  logic [TW-1:0] r_to_cnt;
  state_t        r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic          r_brk, r_ext;
  logic [7:0]    r_key_code;
  logic          r_key_en, r_key_ext, r_key_rel, r_err;

  logic          w_strobe, w_bit, w_timeout, w_frame_ok;

  // NOTE: every flop below uses non-blocking assignment so all of them sample
  // pre-edge values regardless of block ordering.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_clk_s1    <= 1'b1;
      r_clk_s2    <= 1'b1;
      r_dat_s1    <= 1'b1;
      r_dat_s2    <= 1'b1;
      r_clk_flt   <= 1'b1;
      r_clk_flt_d <= 1'b1;
      r_flt_cnt   <= '0;
    end else begin
      r_clk_s1    <= iPS2_CLK;
      r_clk_s2    <= r_clk_s1;
      r_dat_s1    <= iPS2_DAT;
      r_dat_s2    <= r_dat_s1;
      r_clk_flt_d <= r_clk_flt;
      // The filtered level flips only after FILTER_LEN samples in a row disagree.
      if (r_clk_s2 == r_clk_flt) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
        r_clk_flt <= r_clk_s2;
        r_flt_cnt <= '0;
      end else begin
        r_flt_cnt <= r_flt_cnt + 1'b1;
      end
    end
  end

  assign w_strobe   = r_clk_flt_d & ~r_clk_flt;
  assign w_bit      = r_dat_s2;
  assign w_timeout  = (r_state != S_IDLE) && !w_strobe && (r_to_cnt == TW'(TIMEOUT_CYCLES));
  assign w_frame_ok = w_bit && (^{r_shift, r_parity});

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_to_cnt <= '0;
    end else if (w_strobe || w_timeout || r_state == S_IDLE) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_brk      <= 1'b0;
      r_ext      <= 1'b0;
      r_key_code <= 8'h00;
      r_key_en   <= 1'b0;
      r_key_ext  <= 1'b0;
      r_key_rel  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_key_en  <= 1'b0;
      r_key_rel <= 1'b0;
      r_err     <= 1'b0;
      if (w_timeout) begin
        r_state <= S_IDLE;
        r_err   <= 1'b1;
        r_brk   <= 1'b0;
        r_ext   <= 1'b0;
      end else if (w_strobe) begin
        case (r_state)
          S_IDLE: if (!w_bit) begin
            r_state   <= S_DATA;
            r_bit_cnt <= '0;
            r_shift   <= '0;
          end
          S_DATA: begin
            r_shift   <= {w_bit, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_parity <= w_bit;
            r_state  <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (!w_frame_ok) begin
              r_err <= 1'b1;
            end else if (r_shift == 8'hE0) begin
              r_ext <= 1'b1;
            end else if (r_shift == 8'hF0) begin
              r_brk <= 1'b1;
            end else if (r_brk) begin
              r_key_rel <= 1'b1;
              r_brk     <= 1'b0;
              r_ext     <= 1'b0;
            end else begin
              r_key_code <= r_shift;
              r_key_ext  <= r_ext;
              r_key_en   <= 1'b1;
              r_ext      <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign oKEY_CODE = r_key_code;
  assign oKEY_EN   = r_key_en;
  assign oKEY_EXT  = r_key_ext;
  assign oKEY_REL  = r_key_rel;
  assign oERR      = r_err;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Self-checking bench for ps2_key_receiver: frame-level reference model feeding
// an expected-pulse queue, checked every cycle by a single compare process.
module tb_ps2_key_receiver;

  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT    = 1500;
  localparam int HALF       = 25;

  typedef enum int {EV_EN, EV_REL, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] code;
    logic       ext;
  } ev_t;

  logic       clk, rst_n, ps2_clk, ps2_dat;
  logic [7:0] key_code;
  logic       key_en, key_ext, key_rel, err;

  ev_t        exp_q[$];
  logic       m_brk, m_ext;
  logic [7:0] shown_code;
  logic       shown_ext;
  int         n_checks, n_pass;

  ps2_key_receiver #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .iCLK(clk), .iRST_n(rst_n), .iPS2_CLK(ps2_clk), .iPS2_DAT(ps2_dat),
    .oKEY_CODE(key_code), .oKEY_EN(key_en), .oKEY_EXT(key_ext),
    .oKEY_REL(key_rel), .oERR(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input bit ok, input string name, input int act, input int exp_v);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: what a complete frame must produce, from the byte rules.
  task automatic model_frame(input logic [7:0] b, input bit ok);
    ev_t e;
    e.code = b;
    e.ext  = 1'b0;
    if (!ok) begin
      e.kind = EV_ERR;
      exp_q.push_back(e);
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (m_brk) begin
      e.kind = EV_REL;
      exp_q.push_back(e);
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else begin
      e.kind = EV_EN;
      e.ext  = m_ext;
      exp_q.push_back(e);
      m_ext = 1'b0;
    end
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_dat = b;
    if (glitch) begin
      cyc(10);
      ps2_clk = 1'b0;
      cyc(2);
      ps2_clk = 1'b1;
      cyc(HALF - 12);
    end else begin
      cyc(HALF);
    end
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
    logic [10:0] bits;
    bits = frame_bits(b, bad_par, bad_stop);
    model_frame(b, !(bad_par || bad_stop));
    for (int i = 0; i < 11; i++) send_bit(bits[i], glitch);
    ps2_dat = 1'b1;
    cyc(HALF);
    check(exp_q.size() == 0, "pulse_seen", exp_q.size(), 0);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    logic [10:0] bits;
    bits = frame_bits(b, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(bits[i], 1'b0);
  endtask

  // Compare process: every cycle, pulses must match the expected queue in order
  // and the code/ext outputs must hold the last make code.
  always @(negedge clk) begin
    if (!rst_n) begin
      check({key_code, key_en, key_ext, key_rel, err} == 12'h000, "reset_outputs",
            {key_code, key_en, key_ext, key_rel, err}, 0);
    end else begin
      check((int'(key_en) + int'(key_rel) + int'(err)) <= 1, "one_pulse",
            {key_en, key_rel, err}, 0);
      if (key_en || key_rel || err) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_pulse", {key_en, key_rel, err}, 0);
        end else begin
          ev_t e;
          ev_kind_t got;
          e = exp_q.pop_front();
          got = key_en ? EV_EN : (key_rel ? EV_REL : EV_ERR);
          check(got == e.kind, "pulse_kind", int'(got), int'(e.kind));
          if (e.kind == EV_EN && key_en) begin
            check(key_code == e.code && key_ext == e.ext, "make_code",
                  {key_ext, key_code}, {e.ext, e.code});
            shown_code = e.code;
            shown_ext  = e.ext;
          end
        end
      end
      if (!key_en) check(key_code == shown_code && key_ext == shown_ext, "code_hold",
                         {key_ext, key_code}, {shown_ext, shown_code});
    end
  end

  task automatic model_reset();
    exp_q.delete();
    m_brk = 1'b0;
    m_ext = 1'b0;
    shown_code = 8'h00;
    shown_ext  = 1'b0;
  endtask

  initial begin
    logic [7:0] ext_codes [4];
    ext_codes[0] = 8'h75; ext_codes[1] = 8'h72; ext_codes[2] = 8'h6B; ext_codes[3] = 8'h74;
    n_checks = 0;
    n_pass   = 0;
    model_reset();
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1;
    cyc(5);
    rst_n = 1'b1;
    cyc(5);
    check(key_code == 8'h00 && key_ext == 1'b0, "reset_state", {key_ext, key_code}, 0);

    send_frame(8'h1C, 0, 0, 0);
    check(key_code == 8'h1C && key_ext == 1'b0, "lit_1c", {key_ext, key_code}, 9'h01C);

    for (int i = 0; i < 4; i++) begin
      send_frame(8'hE0, 0, 0, 0);
      send_frame(ext_codes[i], 0, 0, 0);
      check(key_code == ext_codes[i] && key_ext == 1'b1, "lit_ext",
            {key_ext, key_code}, {1'b1, ext_codes[i]});
    end

    send_frame(8'h1C, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    check(key_code == 8'h1C && key_ext == 1'b0, "lit_after_break", {key_ext, key_code}, 9'h01C);
    send_frame(8'h1B, 0, 0, 0);
    check(key_code == 8'h1B, "lit_1b", key_code, 8'h1B);

    send_frame(8'h1C, 1, 0, 0);
    send_frame(8'h1C, 0, 1, 0);
    check(key_code == 8'h1B, "lit_bad_frames", key_code, 8'h1B);

    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'h1C, 1, 0, 0);
    send_frame(8'h74, 0, 0, 0);
    check(key_code == 8'h74 && key_ext == 1'b1, "lit_prefix_kept", {key_ext, key_code}, 9'h174);

    // Timeout: prefix then a stalled frame; the error must also drop the prefix.
    send_frame(8'hE0, 0, 0, 0);
    begin
      ev_t e;
      e.kind = EV_ERR; e.code = 8'h00; e.ext = 1'b0;
      exp_q.push_back(e);
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
    send_partial(8'h29, 5);
    ps2_dat = 1'b1;
    cyc(TIMEOUT + 60);
    check(exp_q.size() == 0, "timeout_err", exp_q.size(), 0);
    send_frame(8'h29, 0, 0, 0);
    check(key_code == 8'h29 && key_ext == 1'b0, "lit_29", {key_ext, key_code}, 9'h029);

    send_frame(8'h5A, 0, 0, 1);
    check(key_code == 8'h5A, "lit_glitch_5a", key_code, 8'h5A);

    send_partial(8'h44, 4);
    rst_n = 1'b0;
    model_reset();
    cyc(5);
    check(key_code == 8'h00 && key_ext == 1'b0, "lit_mid_reset", {key_ext, key_code}, 0);
    ps2_dat = 1'b1;
    rst_n = 1'b1;
    cyc(5);
    send_frame(8'h33, 0, 0, 0);
    check(key_code == 8'h33, "lit_after_reset", key_code, 8'h33);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      int sel;
      sel = $urandom_range(0, 9);
      b = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
      send_frame(b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) == 0));
    end

    cyc(20);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
